dense_accumulator: RTL and testbench
====================================

DENSE_ACCUMULATOR -- requirements
Module: dense_accumulator

Interface
REQ-001 SHALL have parameter N, default 16: signed fixed-point word width of data, weights, bias and results.
REQ-002 SHALL have parameter EngineCount, default 16: number of parallel neuron engines.
REQ-003 SHALL have parameter Q, default 8: fractional bits of the fixed-point format.
REQ-004 SHALL have parameter AccW, default 2*N+12: signed accumulator width per engine.
REQ-005 SHALL use one clock, clk_i; reset rst_i SHALL be asynchronous and active-high.
REQ-006 clk_i  input  1: clock, all state changes on rising edge.
REQ-007 rst_i  input  1: asynchronous active-high reset.
REQ-008 start_i  input  1: begin a neuron-vector computation.
REQ-009 input_count_i  input  12: number of input beats (0..4095), sampled with start_i.
REQ-010 data_valid_i  input  1: data_i and weight_i valid this cycle.
REQ-011 data_ready_o  output  1: block accepts a beat this cycle.
REQ-012 data_i  input  N signed: input activation, broadcast to all engines.
REQ-013 weight_i  input  [EngineCount] x N signed: per-engine weight for the current beat.
REQ-014 bias_i  input  [EngineCount] x N signed: per-engine bias, sampled with start_i.
REQ-015 busy_o  output  1: high in any state other than IDLE.
REQ-016 done_o  output  1: one-cycle pulse; value_o updated and valid.
REQ-017 value_o  output  [EngineCount] x N signed: saturated results, direct feed to the activation stage.

Function
REQ-018 States SHALL be IDLE, ACCUM, SCALE, DONE.
REQ-019 IDLE: start_i high and input_count_i != 0 -> load acc[e] = sign-extended bias_i[e] << Q, load beat counter, go ACCUM.
REQ-020 IDLE: start_i high and input_count_i == 0 -> load acc[e] as in REQ-019, go SCALE directly.
REQ-021 start_i SHALL be ignored in every state other than IDLE.
REQ-022 data_ready_o SHALL be high exactly when state is ACCUM.
REQ-023 Beat accepted when data_valid_i and data_ready_o are both high; acc[e] += data_i * weight_i[e] (full 2N-bit signed product, sign-extended to AccW).
REQ-024 Cycles with data_valid_i low in ACCUM SHALL leave acc and counter unchanged.
REQ-025 Counter SHALL decrement per accepted beat; the edge accepting the last beat SHALL move state to SCALE.
REQ-026 SCALE (one cycle): value_o[e] <= sat(acc[e] >>> Q); arithmetic shift, rounding toward minus infinity; go DONE.
REQ-027 sat(): clamp to [-2^(N-1), 2^(N-1)-1].
REQ-028 DONE (one cycle): done_o high, go IDLE.
REQ-029 done_o SHALL be asserted in the second cycle after the last beat is accepted (or after start_i is accepted with input_count_i == 0).
REQ-030 value_o SHALL hold its value outside SCALE edges.
REQ-031 No accumulator overflow detection is required; AccW covers 4095 full-scale products plus bias.
REQ-032 All outputs other than value_o (busy_o, done_o, data_ready_o) SHALL be decoded from the state register.

Reset
REQ-033 On rst_i assertion, at any time: state IDLE, counter 0, acc 0, value_o all 0, done_o 0, busy_o 0, data_ready_o 0.
REQ-034 Reset mid-ACCUM SHALL abandon the computation; no done_o pulse SHALL follow.

Verification (N=16, Q=8, EngineCount=4)
REQ-035 Reset: assert rst_i asynchronously -> all value_o 0, busy_o 0, done_o 0, data_ready_o 0 immediately.
REQ-036 Basic: count 3, bias 0, weight[0]=256, data 256, 512, -256 -> value_o[0]=512, done_o pulse in 2nd cycle after last beat.
REQ-037 Saturation: count 1, data 32767, weight[0]=32767, weight[1]=-32768 -> value_o[0]=32767, value_o[1]=-32768.
REQ-038 Gaps and rounding: same as REQ-036 with data_valid_i toggling every cycle -> same result. Separately, count 1, data -1, weight[0]=1, bias 0 -> value_o[0]=-1.
REQ-039 Zero count and ignored start: count 0, bias[2]=100 -> value_o[2]=100, done_o in 2nd cycle after start; start_i pulsed during ACCUM -> no effect.
REQ-040 Reset mid-ACCUM after 1 of 3 beats -> IDLE, value_o 0, no done_o; a following full run gives the REQ-036 result.

Source files
------------

// File: rtl/dense_accumulator.sv
// Dense-layer neuron engine bank: EngineCount signed fixed-point MACs share one
// broadcast activation stream, then scale by 2^-Q and saturate to N bits.
module dense_accumulator #(
   parameter int N           = 16,
   parameter int EngineCount = 16,
   parameter int Q           = 8,
   parameter int AccW        = 2*N+12
) (
   input  logic                                clk_i,
   input  logic                                rst_i,
   input  logic                                start_i,
   input  logic [11:0]                         input_count_i,
   input  logic                                data_valid_i,
   output logic                                data_ready_o,
   input  logic signed [N-1:0]                 data_i,
   input  logic [EngineCount-1:0][N-1:0]       weight_i,
   input  logic [EngineCount-1:0][N-1:0]       bias_i,
   output logic                                busy_o,
   output logic                                done_o,
   output logic [EngineCount-1:0][N-1:0]       value_o,
   output logic [1:0]                          state_o
);

   localparam logic [1:0] StIdle  = 2'd0;
   localparam logic [1:0] StAccum = 2'd1;
   localparam logic [1:0] StScale = 2'd2;
   localparam logic [1:0] StDone  = 2'd3;

   localparam logic signed [AccW-1:0] SatHi = {{(AccW-N+1){1'b0}}, {(N-1){1'b1}}};
   localparam logic signed [AccW-1:0] SatLo = {{(AccW-N+1){1'b1}}, {(N-1){1'b0}}};

   // Handshake: a beat transfers on a rising edge where data_valid_i and
   // data_ready_o are both high; data_ready_o depends only on the state register.

   logic [1:0]                    state_q, state_d;
   logic [11:0]                   cnt_q, cnt_d;
   logic signed [AccW-1:0]        acc_q [EngineCount];
   logic signed [AccW-1:0]        acc_d [EngineCount];
   logic [EngineCount-1:0][N-1:0] value_q, value_d;
   logic                          beat_ok;

   // Arithmetic shift floors toward minus infinity before clamping.
   function automatic logic [N-1:0] sat_scale(input logic signed [AccW-1:0] a);
      logic signed [AccW-1:0] s;
      s = a >>> Q;
      if (s > SatHi) begin
         return SatHi[N-1:0];
      end else if (s < SatLo) begin
         return SatLo[N-1:0];
      end
      return s[N-1:0];
   endfunction

   function automatic logic signed [AccW-1:0] bias_load(input logic [N-1:0] b);
      logic signed [AccW-1:0] ext;
      ext = $signed({{(AccW-N){b[N-1]}}, b});
      return ext <<< Q;
   endfunction

   function automatic logic signed [AccW-1:0] mac(input logic signed [AccW-1:0] acc,
                                                  input logic signed [N-1:0]    d,
                                                  input logic [N-1:0]           w);
      logic signed [2*N-1:0] prod;
      prod = d * $signed(w);
      return acc + $signed({{(AccW-2*N){prod[2*N-1]}}, prod});
   endfunction

   assign beat_ok = data_valid_i && (state_q == StAccum);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      value_d = value_q;
      for (int e = 0; e < EngineCount; e++) begin
         acc_d[e] = acc_q[e];
      end
      case (state_q)
         StIdle: begin
            if (start_i) begin
               cnt_d = input_count_i;
               for (int e = 0; e < EngineCount; e++) begin
                  acc_d[e] = bias_load(bias_i[e]);
               end
               state_d = (input_count_i != 12'd0) ? StAccum : StScale;
            end
         end
         StAccum: begin
            if (beat_ok) begin
               cnt_d = cnt_q - 12'd1;
               for (int e = 0; e < EngineCount; e++) begin
                  acc_d[e] = mac(acc_q[e], data_i, weight_i[e]);
               end
               if (cnt_q == 12'd1) begin
                  state_d = StScale;
               end
            end
         end
         StScale: begin
            for (int e = 0; e < EngineCount; e++) begin
               value_d[e] = sat_scale(acc_q[e]);
            end
            state_d = StDone;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         value_q <= '0;
         for (int e = 0; e < EngineCount; e++) begin
            acc_q[e] <= '0;
         end
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         value_q <= value_d;
         for (int e = 0; e < EngineCount; e++) begin
            acc_q[e] <= acc_d[e];
         end
      end
   end

   assign data_ready_o = (state_q == StAccum);
   assign busy_o       = (state_q != StIdle);
   assign done_o       = (state_q == StDone);
   assign value_o      = value_q;
   assign state_o      = state_q;

endmodule

// File: tb/tb_dense_accumulator.sv
// Directed bench for dense_accumulator (N=16, Q=8, four engines): vector table
// for complete runs plus hand-written reset and ignored-start sequences.
module tb_dense_accumulator;

   localparam int N  = 16;
   localparam int E  = 4;
   localparam int Q  = 8;
   localparam int MB = 3;

   logic                    clk;
   logic                    rst;
   logic                    start;
   logic [11:0]             count;
   logic                    dvalid;
   logic                    dready;
   logic signed [N-1:0]     data;
   logic [E-1:0][N-1:0]     weight;
   logic [E-1:0][N-1:0]     bias;
   logic                    busy;
   logic                    done;
   logic [E-1:0][N-1:0]     value;
   logic [1:0]              state;

   int checks = 0;
   int errors = 0;

   typedef struct {
      string               name;
      int                  cnt;
      bit                  gaps;
      bit                  mid_start;
      logic signed [N-1:0] b   [E];
      logic signed [N-1:0] d   [MB];
      logic signed [N-1:0] w   [MB][E];
      logic signed [N-1:0] exp_v [E];
   } vec_t;

   vec_t vecs [6];

   dense_accumulator #(.N(N), .EngineCount(E), .Q(Q), .AccW(2*N+12)) dut (
      .clk_i        (clk),
      .rst_i        (rst),
      .start_i      (start),
      .input_count_i(count),
      .data_valid_i (dvalid),
      .data_ready_o (dready),
      .data_i       (data),
      .weight_i     (weight),
      .bias_i       (bias),
      .busy_o       (busy),
      .done_o       (done),
      .value_o      (value),
      .state_o      (state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", nm, $signed(act), act, $signed(req), req);
      end
   endtask

   task automatic check_val(input string nm, input int e, input logic signed [N-1:0] req);
      checks++;
      if (value[e] !== req) begin
         errors++;
         $display("FAIL %s value[%0d]: got %0d, expected %0d", nm, e, $signed(value[e]), req);
      end
   endtask

   task automatic clear_vec(output vec_t v);
      v.name = ""; v.cnt = 0; v.gaps = 0; v.mid_start = 0;
      for (int e = 0; e < E; e++) begin
         v.b[e] = '0; v.exp_v[e] = '0;
      end
      for (int k = 0; k < MB; k++) begin
         v.d[k] = '0;
         for (int e = 0; e < E; e++) v.w[k][e] = '0;
      end
   endtask

   // All driving and sampling happens at negedges, away from the active edge.
   task automatic run_vec(input vec_t v);
      @(negedge clk);
      start = 1'b1;
      count = 12'(v.cnt);
      for (int e = 0; e < E; e++) bias[e] = v.b[e];
      @(negedge clk);
      start = 1'b0;
      bias  = '0;
      for (int k = 0; k < v.cnt; k++) begin
         if (v.gaps) begin
            dvalid = 1'b0;
            data   = 16'sh7fff;
            weight = '1;
            if (v.mid_start) begin
               start = 1'b1;
               count = 12'd0;
               bias  = '1;
            end
            @(negedge clk);
            start = 1'b0;
            bias  = '0;
         end
         check({v.name, " ready"}, {31'd0, dready}, 32'd1);
         dvalid = 1'b1;
         data   = v.d[k];
         for (int e = 0; e < E; e++) weight[e] = v.w[k][e];
         @(negedge clk);
      end
      dvalid = 1'b0;
      data   = '0;
      weight = '0;
      check({v.name, " done early"}, {31'd0, done}, 32'd0);
      check({v.name, " busy"}, {31'd0, busy}, 32'd1);
      @(negedge clk);
      check({v.name, " done pulse"}, {31'd0, done}, 32'd1);
      for (int e = 0; e < E; e++) check_val(v.name, e, v.exp_v[e]);
      @(negedge clk);
      check({v.name, " done single"}, {31'd0, done}, 32'd0);
      check({v.name, " idle"}, {31'd0, busy}, 32'd0);
      for (int e = 0; e < E; e++) check_val({v.name, " hold"}, e, v.exp_v[e]);
   endtask

   initial begin
      rst = 1'b0; start = 1'b0; count = '0; dvalid = 1'b0;
      data = '0; weight = '0; bias = '0;

      // basic: (256*256 + 512*256 - 256*256) >> 8 = 512
      clear_vec(vecs[0]);
      vecs[0].name = "basic"; vecs[0].cnt = 3;
      vecs[0].d[0] = 256; vecs[0].d[1] = 512; vecs[0].d[2] = -256;
      for (int k = 0; k < 3; k++) vecs[0].w[k][0] = 256;
      vecs[0].exp_v[0] = 512;
      // saturation both ways
      clear_vec(vecs[1]);
      vecs[1].name = "sat"; vecs[1].cnt = 1; vecs[1].d[0] = 32767;
      vecs[1].w[0][0] = 32767; vecs[1].w[0][1] = -32768;
      vecs[1].exp_v[0] = 32767; vecs[1].exp_v[1] = -32768;
      // gaps plus ignored start pulses during ACCUM
      vecs[2] = vecs[0];
      vecs[2].name = "gaps"; vecs[2].gaps = 1; vecs[2].mid_start = 1;
      // floor rounding: -1 >>> 8 = -1
      clear_vec(vecs[3]);
      vecs[3].name = "round"; vecs[3].cnt = 1; vecs[3].d[0] = -1;
      vecs[3].w[0][0] = 1; vecs[3].exp_v[0] = -1;
      // zero count: bias passes straight through
      clear_vec(vecs[4]);
      vecs[4].name = "zero"; vecs[4].cnt = 0; vecs[4].b[2] = 100;
      vecs[4].exp_v[2] = 100;
      // mixed signs with bias: -1536>>8=-6, -1408>>8=-6, -768>>8=-3, 776>>8=3
      clear_vec(vecs[5]);
      vecs[5].name = "mixed"; vecs[5].cnt = 2;
      vecs[5].b[0] = 1; vecs[5].b[1] = -2; vecs[5].b[2] = 0; vecs[5].b[3] = 3;
      vecs[5].d[0] = 3; vecs[5].d[1] = -5;
      vecs[5].w[0][0] = 256; vecs[5].w[0][1] = 128; vecs[5].w[0][2] = -256; vecs[5].w[0][3] = 1;
      vecs[5].w[1][0] = 512; vecs[5].w[1][1] = 256; vecs[5].w[1][2] = 0;    vecs[5].w[1][3] = -1;
      vecs[5].exp_v[0] = -6; vecs[5].exp_v[1] = -6; vecs[5].exp_v[2] = -3; vecs[5].exp_v[3] = 3;

      // asynchronous reset, checked before any clock edge it could ride on
      #2 rst = 1'b1;
      #1;
      check("reset busy", {31'd0, busy}, 32'd0);
      check("reset done", {31'd0, done}, 32'd0);
      check("reset ready", {31'd0, dready}, 32'd0);
      check("reset value", value, 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 6; i++) run_vec(vecs[i]);

      // reset mid-ACCUM after one of three beats (value_o holds "mixed" results)
      @(negedge clk);
      start = 1'b1; count = 12'd3; bias = '0;
      @(negedge clk);
      start = 1'b0;
      dvalid = 1'b1; data = 256; weight[0] = 256;
      @(negedge clk);
      dvalid = 1'b0;
      check("midrst ready before", {31'd0, dready}, 32'd1);
      #2 rst = 1'b1;
      #1;
      check("midrst busy", {31'd0, busy}, 32'd0);
      check("midrst ready", {31'd0, dready}, 32'd0);
      for (int e = 0; e < E; e++) check_val("midrst", e, 16'sd0);
      @(negedge clk);
      rst = 1'b0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         check("midrst no done", {31'd0, done}, 32'd0);
         check("midrst stays idle", {31'd0, busy}, 32'd0);
      end
      run_vec(vecs[0]);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
